tx_gearbox: RTL and testbench

Parametrised transmit gearbox converting the 66-bit 64b/66b encoder block stream (2-bit sync header + 64-bit payload) into a continuous DATA_WIDTH-bit PMA word stream. It supports DATA_WIDTH of 32 (block delivered as two 32-bit words) or 64 (one block per cycle). A wrapping sequence counter inserts the required upstream pause cycles through a ready handshake. It sits between the 64b/66b encoder/scrambler and the serializer.

---
 rtl/gearbox_pkg.sv | 23 ++
 rtl/gearbox_seq_ctr.sv | 41 ++++
 rtl/tx_gearbox.sv | 102 ++++++++++
 tb/tb_tx_gearbox.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared constants and period/pause helpers for the 64b/66b transmit gearbox.
package gearbox_pkg;

  localparam int BLOCK_WIDTH = 66;
  localparam int HDR_WIDTH   = 2;

  // Word phase within a 66-bit block when the PMA word is 32 bits wide.
  typedef enum logic {
    PH_FIRST,
    PH_SECOND
  } phase_e;

  // Output words per sequence period: 32 blocks of 66 bits spread over DATA_WIDTH-bit words.
  function automatic int period(input int data_width);
    return 2112 / data_width;
  endfunction

  // Words per period in which upstream is paused so the buffered header bits can drain.
  function automatic int pause(input int data_width);
    return 64 / data_width;
  endfunction

endpackage

// File: rtl/gearbox_seq_ctr.sv
// Wrapping gearbox sequence counter with pause decode and upstream ready generation.
module gearbox_seq_ctr
  import gearbox_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  output logic       ready,
  output logic       accept,
  output logic       advance,
  output logic       wrap,
  output logic [6:0] seq
);

  localparam int PERIOD = period(DATA_WIDTH);
  localparam int PAUSE  = pause(DATA_WIDTH);
  localparam logic [6:0] LAST        = 7'(PERIOD - 1);
  localparam logic [6:0] PAUSE_START = 7'(PERIOD - PAUSE);

  logic pausing;

  // Handshake: a word transfers on a cycle where valid && ready; ready never depends on valid.
  always_comb begin
    pausing = (seq >= PAUSE_START);
    ready   = !reset && !pausing;
    accept  = valid && ready;
    advance = accept || (!reset && pausing);
    wrap    = advance && (seq == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq <= '0;
    end else if (advance) begin
      seq <= wrap ? '0 : seq + 7'd1;
    end
  end

endmodule

// File: rtl/tx_gearbox.sv
// 66-bit block to DATA_WIDTH-bit PMA word gearbox; holds the bit buffer, occupancy and word phase.
module tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [6:0]            o_seq
);
  import gearbox_pkg::*;

  localparam int BUF_W    = DATA_WIDTH + BLOCK_WIDTH - HDR_WIDTH;
  localparam int OCC_W    = $clog2(BUF_W + 1);
  localparam bit TWO_WORD = (DATA_WIDTH == 32);
  localparam logic [OCC_W-1:0] FIRST_LEN  = OCC_W'(DATA_WIDTH + HDR_WIDTH);
  localparam logic [OCC_W-1:0] SECOND_LEN = OCC_W'(32);
  localparam logic [OCC_W-1:0] WORD_LEN   = OCC_W'(DATA_WIDTH);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || HDR_WIDTH != 2) begin : g_bad_cfg
    $error("tx_gearbox: DATA_WIDTH must be 32 or 64 and HDR_WIDTH must be 2");
  end

  logic [BUF_W-1:0] bit_buf_q;
  logic [BUF_W-1:0] in_bits;
  logic [BUF_W-1:0] merged;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] in_len;
  logic [OCC_W-1:0] merged_occ;
  logic [OCC_W-1:0] occ_next;
  phase_e           phase_q;
  logic             accept;
  logic             advance;
  logic             wrap;
  logic             first;

  gearbox_seq_ctr #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_seq_ctr (
    .clk    (i_clk),
    .reset  (i_reset),
    .valid  (i_valid),
    .ready  (o_ready),
    .accept (accept),
    .advance(advance),
    .wrap   (wrap),
    .seq    (o_seq)
  );

  assign first = !TWO_WORD || (phase_q == PH_FIRST);

  // New bits land just above the oldest unsent bits; the low DATA_WIDTH bits go out.
  always_comb begin
    in_bits = '0;
    in_len  = '0;
    if (accept) begin
      if (first) begin
        in_bits = BUF_W'({i_data, i_hdr});
        in_len  = FIRST_LEN;
      end else begin
        in_bits = BUF_W'(i_data);
        in_len  = SECOND_LEN;
      end
    end
    merged     = bit_buf_q | (in_bits << occ_q);
    merged_occ = occ_q + in_len;
    occ_next   = merged_occ - WORD_LEN;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bit_buf_q <= '0;
      occ_q     <= '0;
      phase_q   <= PH_FIRST;
      o_data    <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= advance;
      if (advance) begin
        bit_buf_q <= merged >> DATA_WIDTH;
        occ_q     <= occ_next;
        o_data    <= merged[DATA_WIDTH-1:0];
      end
      if (accept && TWO_WORD) begin
        phase_q <= (phase_q == PH_FIRST) ? PH_SECOND : PH_FIRST;
      end
    end
  end

  // 32 blocks fill exactly one period of words, so the buffer must be empty at every wrap.
  always_ff @(posedge i_clk) begin
    if (!i_reset && wrap) begin
      assert (occ_next == '0);
    end
  end

endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox at DATA_WIDTH 32 and 64: vector table, corner sequences, random streams vs a bit-queue model.
module tb_tx_gearbox;
  import gearbox_pkg::*;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [63:0] data;
  logic [1:0]  hdr;
  logic        sel64;

  logic        rdy32, ov32, rdy64, ov64;
  logic [31:0] od32;
  logic [63:0] od64;
  logic [6:0]  sq32, sq64;

  logic        dut_ready, dut_valid;
  logic [63:0] dut_data;
  logic [6:0]  dut_seq;

  tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) u_dut32 (
    .i_clk  (clk),
    .i_reset(reset || sel64),
    .i_data (data[31:0]),
    .i_hdr  (hdr),
    .i_valid(valid && !sel64),
    .o_ready(rdy32),
    .o_data (od32),
    .o_valid(ov32),
    .o_seq  (sq32)
  );

  tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2)) u_dut64 (
    .i_clk  (clk),
    .i_reset(reset || !sel64),
    .i_data (data),
    .i_hdr  (hdr),
    .i_valid(valid && sel64),
    .o_ready(rdy64),
    .o_data (od64),
    .o_valid(ov64),
    .o_seq  (sq64)
  );

  assign dut_ready = sel64 ? rdy64 : rdy32;
  assign dut_valid = sel64 ? ov64 : ov32;
  assign dut_data  = sel64 ? od64 : {32'b0, od32};
  assign dut_seq   = sel64 ? sq64 : sq32;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required completion within time limit");
    $fatal(1);
  end

  // Reference model state: serial bit queue plus spec-level sequence/phase bookkeeping
  int          dw, per, pau;
  bit          bitq[$];
  logic [63:0] exp_q[$];
  int          mseq;
  bit          mphase;
  bit          exp_valid;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    bit          valid;
    logic [1:0]  hdr;
    logic [63:0] data;
    bit          exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare registered outputs against the model's expectation for the previous edge
  task automatic check_outputs();
    logic [63:0] w;
    check("o_valid", 64'(dut_valid), 64'(exp_valid));
    if (exp_valid && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("o_data", dut_data, w);
    end
    check("o_seq", 64'(dut_seq), 64'(mseq));
  endtask

  task automatic model_clear();
    bitq.delete();
    exp_q.delete();
    mseq      = 0;
    mphase    = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic do_reset(input bit chk, input int n);
    if (chk) check_outputs();
    reset = 1'b1;
    valid = 1'b0;
    #1;
    check("rst_ready", 64'(dut_ready), 64'(0));
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(dut_valid), 64'(0));
    check("rst_data", dut_data, 64'(0));
    check("rst_seq", 64'(dut_seq), 64'(0));
    reset = 1'b0;
    model_clear();
  endtask

  task automatic set_width(input int w);
    sel64 = (w == 64);
    dw    = w;
    per   = period(w);
    pau   = pause(w);
  endtask

  // Driver: one clock cycle, entered and left just after the falling edge
  task automatic cycle(input bit v, input logic [63:0] d, input logic [1:0] h, output bit acc);
    bit          pausing;
    logic [63:0] w;
    check_outputs();
    valid = v;
    data  = d;
    hdr   = h;
    #1;
    pausing = (mseq >= per - pau);
    check("o_ready", 64'(dut_ready), 64'(!pausing));
    acc = v && !pausing;
    if (acc) begin
      if (!mphase) begin
        bitq.push_back(h[0]);
        bitq.push_back(h[1]);
        for (int i = 0; i < dw; i++) bitq.push_back(d[i]);
      end else begin
        for (int i = 0; i < 32; i++) bitq.push_back(d[i]);
      end
      if (dw == 32) mphase = !mphase;
    end
    if (acc || pausing) begin
      w = '0;
      for (int i = 0; i < dw; i++) w[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      exp_q.push_back(w);
      exp_valid = 1'b1;
      mseq = (mseq + 1) % per;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Upstream source: offers a word with probability (100-idle_pct)% and holds it until accepted
  task automatic run_stream(input int n, input int idle_pct);
    bit          holding;
    bit          acc;
    logic [63:0] d;
    logic [1:0]  h;
    holding = 1'b0;
    d = '0;
    h = '0;
    for (int c = 0; c < n; c++) begin
      if (!holding && $urandom_range(0, 99) >= idle_pct) begin
        d = {$urandom, $urandom};
        h = 2'($urandom_range(0, 3));
        holding = 1'b1;
      end
      cycle(holding, d, h, acc);
      if (acc) holding = 1'b0;
    end
  endtask

  initial begin
    bit acc;
    valid = 1'b0;
    data  = '0;
    hdr   = '0;
    reset = 1'b1;
    set_width(32);

    tbl[0] = '{1'b1, 2'b01, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'h0000_0000_FFFF_FFFD};
    tbl[1] = '{1'b1, 2'b11, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0003};
    tbl[2] = '{1'b1, 2'b10, 64'h0000_0000_1234_5678, 1'b1, 64'h0000_0000_2345_6788};
    tbl[3] = '{1'b0, 2'b00, 64'h0000_0000_0000_0000, 1'b0, 64'h0};
    tbl[4] = '{1'b1, 2'b00, 64'h0000_0000_AAAA_AAAA, 1'b1, 64'h0000_0000_AAAA_AAA1};
    tbl[5] = '{1'b1, 2'b11, 64'h0000_0000_0000_FFFF, 1'b1, 64'h0000_0000_003F_FFFA};

    do_reset(1'b0, 3);

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].valid, tbl[i].data, tbl[i].hdr, acc);
      check($sformatf("tbl%0d_valid", i), 64'(dut_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), dut_data, tbl[i].exp_data);
    end

    // Reset after only the first word of a block: partial block is dropped
    do_reset(1'b1, 2);
    cycle(1'b1, 64'h0000_0000_DEAD_BEEF, 2'b10, acc);
    do_reset(1'b1, 1);
    cycle(1'b1, 64'h0000_0000_0F0F_0F0F, 2'b01, acc);
    check("post_rst_hdr", 64'(dut_data[1:0]), 64'(2'b01));
    check("post_rst_seq", 64'(dut_seq), 64'(1));
    cycle(1'b1, 64'h0000_0000_5555_0000, 2'b00, acc);

    // Back-to-back, then 30% idle, at width 32
    run_stream(150, 0);
    run_stream(300, 30);

    // Width 64: full rate then gapped
    check_outputs();
    set_width(64);
    do_reset(1'b0, 3);
    run_stream(80, 0);
    run_stream(200, 30);

    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
